// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ
// writeback requesters; also flags read-after-write hazards and sticky bad writes.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_hold,
  output logic                      o_rf_write,
  output logic [ADDR_W-1:0]         o_rf_ctrl_write,
  output logic [DATA_W-1:0]         o_rf_write_val,
  output logic [ID_W-1:0]           o_grant_id,
  input  logic [ADDR_W-1:0]         i_rd_addr1,
  input  logic [ADDR_W-1:0]         i_rd_addr2,
  output logic                      o_hazard1,
  output logic                      o_hazard2,
  output logic                      o_err_addr
);

  localparam logic [ID_W:0]   NREQ_W   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [ADDR_W:0] NREGS_W  = (ADDR_W+1)'(NUM_REGS);

  logic [ID_W-1:0]   rr_ptr_r;
  logic              rf_write_r;
  logic [ADDR_W-1:0] rf_addr_r;
  logic [DATA_W-1:0] rf_data_r;
  logic [ID_W-1:0]   grant_id_r;
  logic              err_addr_r;

  logic [ADDR_W-1:0] req_addr_s [NUM_REQ];
  logic [DATA_W-1:0] req_data_s [NUM_REQ];
  logic [ID_W:0]     cand_sum_s [NUM_REQ];
  logic [ID_W-1:0]   cand_idx_s [NUM_REQ];
  logic              grant_vld_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_legal_s;
  logic [NUM_REQ-1:0] ready_s;
  logic              hazard1_s;
  logic              hazard2_s;

  // Unpack the flat requester buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_addr_s[k] = i_req_addr[k*ADDR_W +: ADDR_W];
      req_data_s[k] = i_req_data[k*DATA_W +: DATA_W];
    end
  end

  // Search order rr_ptr, rr_ptr+1, ... wrapped modulo NUM_REQ.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum_s[i] = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      if (cand_sum_s[i] >= NREQ_W) begin
        cand_idx_s[i] = ID_W'(cand_sum_s[i] - NREQ_W);
      end else begin
        cand_idx_s[i] = cand_sum_s[i][ID_W-1:0];
      end
    end
  end

  // First valid requester in search order wins; hold and reset suppress grants.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld_s && i_req_valid[cand_idx_s[i]]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = cand_idx_s[i];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (i_hold || !i_rst_n) begin
      grant_vld_s = 1'b0;
    end else begin
      grant_vld_s = grant_vld_s;
    end
  end

  // One-hot ready vector from the winning index.
  always_comb begin
    ready_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_vld_s && (grant_id_s == ID_W'(k))) begin
        ready_s[k] = 1'b1;
      end else begin
        ready_s[k] = 1'b0;
      end
    end
  end

  // Select the winner's address and data; pointer advances past the winner.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id_s == ID_W'(k)) begin
        sel_addr_s = req_addr_s[k];
        sel_data_s = req_data_s[k];
      end else begin
        sel_addr_s = sel_addr_s;
        sel_data_s = sel_data_s;
      end
    end
    sel_legal_s = ({1'b0, sel_addr_s} < NREGS_W);
    if (grant_id_s == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_s + ID_W'(1);
    end
  end

  // Hazard: staged write or any valid (waiting or granted) request hits a read address.
  always_comb begin
    hazard1_s = rf_write_r && (rf_addr_r == i_rd_addr1);
    hazard2_s = rf_write_r && (rf_addr_r == i_rd_addr2);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_req_valid[k] && (req_addr_s[k] == i_rd_addr1)) begin
        hazard1_s = 1'b1;
      end else begin
        hazard1_s = hazard1_s;
      end
      if (i_req_valid[k] && (req_addr_s[k] == i_rd_addr2)) begin
        hazard2_s = 1'b1;
      end else begin
        hazard2_s = hazard2_s;
      end
    end
  end

  // Output stage and arbitration pointer; an out-of-range write is consumed but not issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_r   <= '0;
      rf_write_r <= 1'b0;
      rf_addr_r  <= '0;
      rf_data_r  <= '0;
      grant_id_r <= '0;
      err_addr_r <= 1'b0;
    end else if (grant_vld_s) begin
      rr_ptr_r   <= next_ptr_s;
      rf_write_r <= sel_legal_s;
      rf_addr_r  <= sel_addr_s;
      rf_data_r  <= sel_data_s;
      grant_id_r <= grant_id_s;
      err_addr_r <= err_addr_r | ~sel_legal_s;
    end else begin
      rf_write_r <= 1'b0;
    end
  end

  assign o_req_ready     = ready_s;
  assign o_rf_write      = rf_write_r;
  assign o_rf_ctrl_write = rf_addr_r;
  assign o_rf_write_val  = rf_data_r;
  assign o_grant_id      = grant_id_r;
  assign o_err_addr      = err_addr_r;
  assign o_hazard1       = hazard1_s;
  assign o_hazard2       = hazard2_s;

  regfile_write_arbiter_chk #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_chk (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .i_hold          (i_hold),
    .o_req_ready     (ready_s),
    .o_rf_write      (rf_write_r),
    .o_rf_ctrl_write (rf_addr_r)
  );

endmodule

// Protocol properties of the arbiter: one-hot grants, grants only to valid
// requesters, nothing granted under hold, never an out-of-range write enable.
module regfile_write_arbiter_chk #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  input logic [NUM_REQ-1:0] i_req_valid,
  input logic               i_hold,
  input logic [NUM_REQ-1:0] o_req_ready,
  input logic               o_rf_write,
  input logic [ADDR_W-1:0]  o_rf_ctrl_write
);

  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NUM_REGS);

  a_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_ready));
  a_ready_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_req_ready & ~i_req_valid) == '0);
  a_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_hold |-> (o_req_ready == '0));
  a_legal_write: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_rf_write |-> ({1'b0, o_rf_ctrl_write} < NREGS_W));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-free behavioural model
// of round-robin arbitration, the output stage and a register-file image.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 16;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [N-1:0]    i_req_valid = '0;
  logic [N*AW-1:0] i_req_addr = '0;
  logic [N*DW-1:0] i_req_data = '0;
  logic [N-1:0]    o_req_ready;
  logic            i_hold = 1'b0;
  logic            o_rf_write;
  logic [AW-1:0]   o_rf_ctrl_write;
  logic [DW-1:0]   o_rf_write_val;
  logic [1:0]      o_grant_id;
  logic [AW-1:0]   i_rd_addr1 = '0;
  logic [AW-1:0]   i_rd_addr2 = '0;
  logic            o_hazard1;
  logic            o_hazard2;
  logic            o_err_addr;

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data), .o_req_ready(o_req_ready), .i_hold(i_hold),
    .o_rf_write(o_rf_write), .o_rf_ctrl_write(o_rf_ctrl_write), .o_rf_write_val(o_rf_write_val),
    .o_grant_id(o_grant_id), .i_rd_addr1(i_rd_addr1), .i_rd_addr2(i_rd_addr2),
    .o_hazard1(o_hazard1), .o_hazard2(o_hazard2), .o_err_addr(o_err_addr)
  );

  always #5 i_clk = ~i_clk;

  // register file image driven from the DUT's write port, committed on the falling edge
  logic [DW-1:0] dut_rf [32];
  always @(negedge i_clk) if (o_rf_write) dut_rf[o_rf_ctrl_write] <= o_rf_write_val;

  int checks = 0;
  int failures = 0;

  // stimulus state
  bit          rv [N];
  int          ra [N];
  logic [31:0] rdat [N];
  int          rd1, rd2;
  bit          hold;

  // model state
  int          mptr;
  bit          m_wr;
  int          m_addr;
  logic [31:0] m_data;
  int          m_gid;
  bit          m_err;
  logic [31:0] mreg [32];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mptr = 0; m_wr = 0; m_addr = 0; m_data = 0; m_gid = 0; m_err = 0;
  endtask

  function automatic int model_grant();
    int g = -1;
    if (!hold) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && rv[(mptr + i) % N]) g = (mptr + i) % N;
      end
    end
    return g;
  endfunction

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      i_req_valid[k] = rv[k];
      i_req_addr[k*AW +: AW] = AW'(ra[k]);
      i_req_data[k*DW +: DW] = rdat[k];
    end
    i_rd_addr1 = AW'(rd1);
    i_rd_addr2 = AW'(rd2);
    i_hold = hold;
  endtask

  // one clock: check combinational outputs, clock, advance model, check registered outputs
  task automatic cycle(output int g);
    int exp_ready;
    bit h1, h2;
    apply();
    #1;
    g = model_grant();
    exp_ready = (g < 0) ? 0 : (1 << g);
    h1 = m_wr && (m_addr == rd1);
    h2 = m_wr && (m_addr == rd2);
    for (int k = 0; k < N; k++) begin
      if (rv[k] && ra[k] == rd1) h1 = 1;
      if (rv[k] && ra[k] == rd2) h2 = 1;
    end
    check_eq("ready", 64'(o_req_ready), 64'(exp_ready));
    check_eq("hazard1", 64'(o_hazard1), 64'(h1));
    check_eq("hazard2", 64'(o_hazard2), 64'(h2));
    @(posedge i_clk);
    if (g >= 0) begin
      mptr = (g + 1) % N;
      m_wr = (ra[g] < NR);
      m_addr = ra[g];
      m_data = rdat[g];
      m_gid = g;
      if (ra[g] >= NR) m_err = 1;
      else mreg[ra[g]] = rdat[g];
    end else begin
      m_wr = 0;
    end
    #1;
    check_eq("rf_write", 64'(o_rf_write), 64'(m_wr));
    check_eq("rf_addr", 64'(o_rf_ctrl_write), 64'(m_addr));
    check_eq("rf_data", 64'(o_rf_write_val), 64'(m_data));
    check_eq("grant_id", 64'(o_grant_id), 64'(m_gid));
    check_eq("err_addr", 64'(o_err_addr), 64'(m_err));
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int g;
    for (int r = 0; r < 32; r++) begin
      dut_rf[r] = '0;
      mreg[r] = '0;
    end
    model_reset();
    hold = 0; rd1 = 31; rd2 = 30;

    // reset with all requesters valid
    for (int k = 0; k < N; k++) begin
      rv[k] = 1; ra[k] = k + 1; rdat[k] = $urandom;
    end
    apply();
    #12;
    check_eq("rst_ready", 64'(o_req_ready), 64'(0));
    check_eq("rst_write", 64'(o_rf_write), 64'(0));
    check_eq("rst_addr", 64'(o_rf_ctrl_write), 64'(0));
    check_eq("rst_data", 64'(o_rf_write_val), 64'(0));
    check_eq("rst_gid", 64'(o_grant_id), 64'(0));
    check_eq("rst_err", 64'(o_err_addr), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // round robin with all valid: 0,1,2,0,1,2,0
    for (int c = 0; c < 7; c++) cycle(g);

    // same-address collision, rr_ptr = 0
    pulse_reset();
    rv[0] = 1; ra[0] = 4; rdat[0] = 32'hAAAA0000;
    rv[1] = 0;
    rv[2] = 1; ra[2] = 4; rdat[2] = 32'h5555FFFF;
    for (int c = 0; c < 4; c++) begin
      cycle(g);
      if (g >= 0) rv[g] = 0;
    end
    check_eq("collision_reg4", 64'(dut_rf[4]), 64'(32'h5555FFFF));

    // illegal address is consumed, error sticks through legal writes
    rv[1] = 1; ra[1] = 20; rdat[1] = 32'h12345678;
    cycle(g);
    rv[1] = 0;
    check_eq("illegal_err", 64'(o_err_addr), 64'(1));
    rv[0] = 1; ra[0] = 9; rdat[0] = 32'hCAFEF00D;
    cycle(g);
    rv[0] = 0;
    cycle(g);
    check_eq("err_sticky", 64'(o_err_addr), 64'(1));

    // hazard on a single write to address 7
    rd1 = 7; rd2 = 2;
    rv[0] = 1; ra[0] = 7; rdat[0] = 32'h00000777;
    cycle(g);
    rv[0] = 0;
    cycle(g);
    cycle(g);
    check_eq("hazard1_clear", 64'(o_hazard1), 64'(0));

    // hold blocks grants but hazards still see waiting requests
    hold = 1; rd1 = 6;
    for (int k = 0; k < N; k++) begin
      rv[k] = 1; ra[k] = 5 + k; rdat[k] = $urandom;
    end
    for (int c = 0; c < 4; c++) cycle(g);
    hold = 0;

    // randomized traffic: requests held until granted
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(7) == 0);
      for (int k = 0; k < N; k++) begin
        if (!rv[k] && $urandom_range(2) != 0) begin
          rv[k] = 1;
          ra[k] = ($urandom_range(5) == 0) ? int'($urandom_range(31)) : int'($urandom_range(15));
          rdat[k] = $urandom;
        end
      end
      rd1 = ($urandom_range(1) == 1) ? ra[$urandom_range(N-1)] : int'($urandom_range(31));
      rd2 = ($urandom_range(1) == 1) ? ra[$urandom_range(N-1)] : int'($urandom_range(31));
      cycle(g);
      if (g >= 0) rv[g] = 0;
    end
    hold = 0;
    for (int k = 0; k < N; k++) rv[k] = 0;
    cycle(g);
    cycle(g);
    for (int r = 0; r < NR; r++) check_eq($sformatf("rf_reg%0d", r), 64'(dut_rf[r]), 64'(mreg[r]));

    // reset in the middle of back-to-back writes
    for (int k = 0; k < N; k++) begin
      rv[k] = 1; ra[k] = 10 + k; rdat[k] = $urandom;
    end
    for (int c = 0; c < 2; c++) cycle(g);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_write", 64'(o_rf_write), 64'(0));
    check_eq("midrst_ready", 64'(o_req_ready), 64'(0));
    check_eq("midrst_gid", 64'(o_grant_id), 64'(0));
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle(g);
    check_eq("midrst_first_gid", 64'(o_grant_id), 64'(0));
    cycle(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
